// File: rtl/mem_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// mem_fetch_unit_pkg
// Types shared by the fetch unit and the icache side of the line interface:
//   ADDR_TP  - 32-bit byte address
//   WORD_TP  - one RAM byte
//   LINE_TP  - one cache line, byte i at bits 8i+7:8i
//   LINE_LN  - bytes per line
//   IDX_TP   - byte index inside a line
// line_base() aligns an address down to the start of its line.
// -----------------------------------------------------------------------------
package mem_fetch_unit_pkg;

    localparam int LINE_LN = 16;

    typedef logic [31:0]            ADDR_TP;
    typedef logic [7:0]             WORD_TP;
    typedef logic [LINE_LN*8-1:0]   LINE_TP;
    typedef logic [$clog2(LINE_LN)-1:0] IDX_TP;

    // Clear the in-line offset bits so the result is 16-byte aligned.
    function automatic ADDR_TP line_base(input ADDR_TP addr);
        ADDR_TP a;
        a      = addr;
        a[3:0] = 4'b0000;
        return a;
    endfunction

endpackage

// File: rtl/mem_fetch_unit_line_assembler.sv
// -----------------------------------------------------------------------------
// line_assembler
// Byte-addressed line register: one byte is written per enabled edge at the
// given index; clear zeroes the whole line.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   clr_i       - synchronous clear of all bytes
//   we_i        - write enable for this edge
//   idx_i       - byte index to write
//   data_i      - byte to write
//   line_o      - current line contents (registered)
// -----------------------------------------------------------------------------
module line_assembler #(
    parameter int NBYTES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr_i,
    input  logic                      we_i,
    input  logic [$clog2(NBYTES)-1:0] idx_i,
    input  logic [7:0]                data_i,
    output logic [NBYTES*8-1:0]       line_o
);

    logic [NBYTES*8-1:0] line_q;

    // Byte storage: reset/clear zeroes, otherwise a single indexed byte write.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            line_q <= {(NBYTES*8){1'b0}};
        end else if (we_i) begin
            line_q[{idx_i, 3'b000} +: 8] <= data_i;
        end
    end

    assign line_o = line_q;

endmodule

// File: rtl/mem_fetch_unit.sv
// -----------------------------------------------------------------------------
// mem_fetch_unit
// Fetches one 16-byte line from a byte-wide RAM on behalf of the icache.
// Address issue runs one byte ahead of data capture; a stall (rdy=0) inside
// the read loop is recovered by re-issuing the next byte still to capture.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   rdy                 - global ready, low freezes the unit
//   fc_ena, fc_addr     - line request from icache (held until fc_done)
//   fc_done, fc_line    - one-cycle completion pulse with the fetched line
//   bus_req, bus_gnt    - RAM bus arbitration
//   ram_a, ram_wr       - RAM byte address (registered), write strobe (always 0)
//   ram_din             - RAM read data for the current ram_a
// -----------------------------------------------------------------------------
module mem_fetch_unit
    import mem_fetch_unit_pkg::*;
#(
    parameter int LINE_BYTES = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    input  logic         fc_ena,
    input  logic [31:0]  fc_addr,
    output logic         fc_done,
    output logic [127:0] fc_line,
    output logic         bus_req,
    input  logic         bus_gnt,
    output logic [31:0]  ram_a,
    output logic         ram_wr,
    input  logic [7:0]   ram_din
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_READ = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;
    ADDR_TP base_q, base_d;
    ADDR_TP ram_a_q, ram_a_d;
    LINE_TP fc_line_q, fc_line_d;
    LINE_TP asm_line_s;
    IDX_TP  issue_q, issue_d;
    IDX_TP  cap_q, cap_d;
    logic   bus_req_q, bus_req_d;
    logic   fc_done_q, fc_done_d;
    logic   resume_q, resume_d;
    logic   asm_we_s, asm_clr_s;

    line_assembler #(
        .NBYTES (LINE_BYTES)
    ) u_line_assembler (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (asm_clr_s),
        .we_i   (asm_we_s),
        .idx_i  (cap_q),
        .data_i (ram_din),
        .line_o (asm_line_s)
    );

    // State and output registers; reset wins over everything, including rdy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            base_q    <= 32'd0;
            ram_a_q   <= 32'd0;
            fc_line_q <= {(LINE_LN*8){1'b0}};
            issue_q   <= 4'd0;
            cap_q     <= 4'd0;
            bus_req_q <= 1'b0;
            fc_done_q <= 1'b0;
            resume_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            ram_a_q   <= ram_a_d;
            fc_line_q <= fc_line_d;
            issue_q   <= issue_d;
            cap_q     <= cap_d;
            bus_req_q <= bus_req_d;
            fc_done_q <= fc_done_d;
            resume_q  <= resume_d;
        end
    end

    // Next-state logic: freeze on !rdy, then abort, resume, or normal pipeline.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        ram_a_d   = ram_a_q;
        fc_line_d = fc_line_q;
        issue_d   = issue_q;
        cap_d     = cap_q;
        bus_req_d = bus_req_q;
        fc_done_d = fc_done_q;
        resume_d  = resume_q;
        asm_we_s  = 1'b0;
        asm_clr_s = 1'b0;

        if (!rdy) begin
            // Remember that the read pipeline lost its in-flight byte.
            resume_d = resume_q | (state_q == ST_READ);
        end else begin
            resume_d  = 1'b0;
            fc_done_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (fc_ena) begin
                        state_d   = ST_REQ;
                        bus_req_d = 1'b1;
                        base_d    = line_base(fc_addr);
                        asm_clr_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (!fc_ena) begin
                        state_d   = ST_IDLE;
                        bus_req_d = 1'b0;
                    end else if (bus_gnt) begin
                        state_d = ST_READ;
                        ram_a_d = base_q;
                        issue_d = 4'd0;
                        cap_d   = 4'd0;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                ST_READ: begin
                    if (!fc_ena) begin
                        state_d   = ST_IDLE;
                        bus_req_d = 1'b0;
                    end else if (resume_q) begin
                        // Bubble edge: ram_din is stale, re-issue the next byte to capture.
                        ram_a_d = base_q + {28'd0, cap_q};
                        issue_d = cap_q;
                    end else begin
                        asm_we_s = 1'b1;
                        cap_d    = cap_q + 4'd1;
                        if (issue_q != 4'd15) begin
                            ram_a_d = base_q + {28'd0, issue_q} + 32'd1;
                            issue_d = issue_q + 4'd1;
                        end else begin
                            ram_a_d = ram_a_q;
                            issue_d = issue_q;
                        end
                        if (cap_q == 4'd15) begin
                            // Last byte bypasses the assembler straight into the output line.
                            fc_line_d          = asm_line_s;
                            fc_line_d[127:120] = ram_din;
                            fc_done_d          = 1'b1;
                            bus_req_d          = 1'b0;
                            state_d            = ST_DONE;
                        end else begin
                            state_d = ST_READ;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d   = ST_IDLE;
                    bus_req_d = 1'b0;
                end
            endcase
        end
    end

    assign fc_done = fc_done_q;
    assign fc_line = fc_line_q;
    assign bus_req = bus_req_q;
    assign ram_a   = ram_a_q;
    assign ram_wr  = 1'b0;

endmodule
